key_event_sched: RTL and testbench
==================================

Name: key_event_sched

Overview:
- Sits between the PS/2 decoder and the Spectrum keyboard matrix.
- Merges two key-event sources into one paced, toggle-strobed event stream in ps2_key format:
  - live keystrokes from the PS/2 decoder;
  - scripted macros (auto-typing) read from an external macro ROM.
- Enforces a minimum gap between emitted events so ROM keyboard scans see every press and release.
- Supports aborting a running macro with ESC; on abort it auto-releases any keys the macro still holds.

Parameters:
- GAP_CYCLES, 7000000, minimum clk_sys cycles between consecutive emitted events.
- WAIT_UNIT, 70000, clk_sys cycles per unit of a macro WAIT opcode.
- LIVE_DEPTH, 8, live-event FIFO depth (power of 2).
- ROM_AW, 8, macro ROM address width.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_key  in  11  live event: [10] toggles per event, [9] pressed, [8] extended, [7:0] scancode.
- macro_start  in  1  single-cycle request to start a macro.
- macro_base  in  ROM_AW  first ROM address of the macro to run; sampled with macro_start.
- rom_addr  out  ROM_AW  macro ROM read address.
- rom_data  in  10  macro ROM word {op[1:0], arg[7:0]}; valid exactly 1 cycle after rom_addr changes.
- key_out  out  11  merged event stream, same format as ps2_key.
- busy  out  1  high while a macro is running or aborting.
- ovf  out  1  one-cycle pulse when a live event is dropped.

Behaviour:
- Reset values (async, reset_n low): key_out=0, busy=0, ovf=0, rom_addr=0. Also cleared: FIFO empty, held table empty, gap counter 0, state IDLE.
- Live capture:
  - A change of ps2_key[10] relative to its registered copy enqueues ps2_key[9:0].
  - FIFO full: the event is dropped and ovf pulses the next cycle.
  - Exception: an ESC press (code 0x76, pressed=1, extended=0) arriving while busy is not enqueued; it requests abort.
- Emission:
  - An event is emitted only when the gap counter is 0.
  - Emitting sets key_out[9:0] to the event, toggles key_out[10], and loads the gap counter with GAP_CYCLES-1. The counter decrements to 0.
  - At most one emit per cycle.
- Source priority: abort releases first, then macro events, then the live FIFO. The FIFO emits only in IDLE.
- Macro opcodes:
  - 00 END: macro finishes.
  - 01 PRESS: emit arg as a press.
  - 10 RELEASE: emit arg as a release.
  - 11 WAIT: idle for arg*WAIT_UNIT cycles. arg=0 means no delay.
  - Macro events are never extended (bit8=0).
- Macro FSM states: IDLE, FETCH, DECODE, EMIT, DELAY, ABORT.
  - IDLE: on macro_start, set rom_addr<=macro_base, set busy=1, go to FETCH. macro_start while busy is ignored.
  - FETCH: wait 1 cycle for rom_data, then go to DECODE.
  - DECODE:
    - END: busy<=0, go to IDLE.
    - WAIT: load the delay counter, go to DELAY.
    - PRESS/RELEASE: go to EMIT.
  - EMIT: wait until the gap counter is 0, emit, update the held table, increment rom_addr, go to FETCH.
  - DELAY: count down, then increment rom_addr and go to FETCH.
- Held table (4 entries):
  - PRESS adds its code if absent and a slot is free; if the table is full the code is still emitted but not tracked.
  - RELEASE removes a matching entry.
- Abort:
  - The ESC-press request is honoured from any busy state except ABORT. It takes effect at the next state boundary. An EMIT already waiting is cancelled.
  - ABORT emits one release per held entry, lowest index first, each respecting the gap.
  - Then the held table is cleared, busy<=0, and the state returns to IDLE. The ESC press itself is not emitted; its later release is captured as a normal live event.
- rom_addr wraps modulo 2^ROM_AW.
- A simultaneous live event and macro_start are both accepted: the event is queued, the macro starts.
- reset_n asserted mid-operation aborts without emitting releases. Downstream clears its matrix on its own reset.

Decomposition:
- Package key_sched_pkg holds:
  - opcode localparams OP_END, OP_PRESS, OP_RELEASE, OP_WAIT;
  - ESC code 8'h76;
  - a typedef for the 10-bit event {pressed, ext, code}.
- One sub-module key_evt_fifo: synchronous FIFO with depth LIVE_DEPTH, push/pop/full/empty, async active-low reset.

Test Plan:
- Live only, GAP_CYCLES=4: three ps2_key toggles 1 cycle apart (codes 0x1C, 0x1B, 0x23) -> key_out emits all three in order, ≥4 cycles apart; key_out[10] toggles 3 times.
- Macro {01_3B, 10_3B, 11_02, 01_5A, 10_5A, 00_00} with WAIT_UNIT=10 -> emits J press/release, then a delay ≥20 cycles, then Enter press/release; busy falls the cycle after END decode.
- Live events arriving during a macro -> queued and emitted only after busy falls, in arrival order.
- 9 live toggles inside one gap with LIVE_DEPTH=8 -> 8 events emitted, ovf pulses once.
- Macro presses 0x12 and 0x1A, then ESC press during a WAIT -> emits release 0x12 then release 0x1A, busy falls, no ESC press is emitted.
- reset_n pulsed low during EMIT -> key_out=0 and busy=0 immediately; no further events emitted.

Source files
------------

// File: rtl/key_sched_pkg.sv
// key_sched_pkg: shared definitions for the key event scheduler.
// Holds the macro ROM opcodes, the ESC scancode, the size of the held-key
// table, the 10-bit key event layout and the macro FSM state encoding.
package key_sched_pkg;

  // Macro ROM word is {op[1:0], arg[7:0]}
  localparam logic [1:0] OP_END     = 2'b00;
  localparam logic [1:0] OP_PRESS   = 2'b01;
  localparam logic [1:0] OP_RELEASE = 2'b10;
  localparam logic [1:0] OP_WAIT    = 2'b11;

  localparam logic [7:0] ESC_CODE = 8'h76;

  // Number of macro-pressed keys remembered for auto-release on abort
  localparam int HELD_N = 4;

  // Event payload in ps2_key bit order: [9] pressed, [8] extended, [7:0] code
  typedef struct packed {
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } key_evt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EMIT,
    ST_DELAY,
    ST_ABORT
  } sched_state_t;

endpackage

// File: rtl/key_evt_fifo.sv
// key_evt_fifo: small synchronous FIFO buffering live key events.
// Ports:
//   clk_sys  - system clock
//   reset_n  - asynchronous active-low reset (empties the FIFO)
//   push/din - write one event; ignored while full
//   pop/dout - dout shows the head entry; pop discards it; ignored while empty
//   full     - no room for another event
//   empty    - nothing stored
// DEPTH must be a power of two, at least 2.
module key_evt_fifo
  import key_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk_sys,
  input  logic     reset_n,
  input  logic     push,
  input  key_evt_t din,
  input  logic     pop,
  output key_evt_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  key_evt_t    mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk_sys) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/key_event_sched.sv
// key_event_sched: merges live PS/2 key events and ROM-scripted macros into
// one paced, toggle-strobed event stream for the Spectrum keyboard matrix.
// Ports:
//   clk_sys     - system clock
//   reset_n     - asynchronous active-low reset
//   ps2_key     - live event, [10] toggles per event, [9:0] = key_evt_t
//   macro_start - one-cycle request to run the macro at macro_base
//   macro_base  - first ROM address of the macro, sampled with macro_start
//   rom_addr    - macro ROM read address
//   rom_data    - macro ROM word {op, arg}, valid one cycle after rom_addr
//   key_out     - merged event stream, same format as ps2_key
//   busy        - a macro is running or being aborted
//   ovf         - one-cycle pulse when a live event was dropped (FIFO full)
module key_event_sched
  import key_sched_pkg::*;
#(
  parameter int GAP_CYCLES = 7000000,
  parameter int WAIT_UNIT  = 70000,
  parameter int LIVE_DEPTH = 8,
  parameter int ROM_AW     = 8
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [10:0]       ps2_key,
  input  logic              macro_start,
  input  logic [ROM_AW-1:0] macro_base,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [9:0]        rom_data,
  output logic [10:0]       key_out,
  output logic              busy,
  output logic              ovf
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int DLY_W = $clog2(255 * WAIT_UNIT + 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_ONE  = 1;
  localparam logic [DLY_W-1:0]  DLY_ONE  = 1;
  localparam logic [ROM_AW-1:0] ADDR_ONE = 1;
  localparam logic [2:0]        AB_DONE  = 3'(HELD_N);

  sched_state_t state_q, state_d;

  logic                     tog_q, tog_d;
  logic [ROM_AW-1:0]        rom_addr_q, rom_addr_d;
  logic [10:0]              key_out_q, key_out_d;
  logic                     busy_q, busy_d;
  logic                     ovf_q, ovf_d;
  logic                     abort_pend_q, abort_pend_d;
  logic [GAP_W-1:0]         gap_q, gap_d;
  logic [DLY_W-1:0]         dly_q, dly_d;
  logic [1:0]               cur_op_q, cur_op_d;
  logic [7:0]               cur_arg_q, cur_arg_d;
  logic [HELD_N-1:0]        held_vld_q, held_vld_d;
  logic [HELD_N-1:0][7:0]   held_code_q, held_code_d;
  logic [2:0]               ab_idx_q, ab_idx_d;

  key_evt_t live_evt, fifo_dout, mac_evt, emit_evt;
  logic     new_evt, esc_abort, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic     gap_zero, mac_emit, emit, held_hit, free_ok;
  logic [1:0] free_idx;

  assign rom_addr = rom_addr_q;
  assign key_out  = key_out_q;
  assign busy     = busy_q;
  assign ovf      = ovf_q;
  assign gap_zero = (gap_q == '0);
  assign live_evt = key_evt_t'(ps2_key[9:0]);

  // Live capture. An ESC press during a macro is swallowed and turned into
  // an abort request instead of being queued.
  always_comb begin
    tog_d     = ps2_key[10];
    new_evt   = ps2_key[10] ^ tog_q;
    esc_abort = new_evt && busy_q && live_evt.pressed && !live_evt.ext &&
                (live_evt.code == ESC_CODE);
    fifo_push = new_evt && !esc_abort;
    ovf_d     = fifo_push && fifo_full;
  end

  key_evt_fifo #(
    .DEPTH (LIVE_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (live_evt),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Held-table lookup for the current macro argument; the descending loop
  // leaves the lowest free slot in free_idx.
  always_comb begin
    held_hit = 1'b0;
    free_ok  = 1'b0;
    free_idx = '0;
    for (int i = HELD_N - 1; i >= 0; i--) begin
      if (held_vld_q[i] && (held_code_q[i] == cur_arg_q)) held_hit = 1'b1;
      if (!held_vld_q[i]) begin
        free_ok  = 1'b1;
        free_idx = 2'(i);
      end
    end
  end

  // Macro FSM. A pending abort pre-empts whatever transition a busy state
  // would otherwise take, including an EMIT that is still waiting.
  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    busy_d       = busy_q;
    dly_d        = dly_q;
    cur_op_d     = cur_op_q;
    cur_arg_d    = cur_arg_q;
    held_vld_d   = held_vld_q;
    held_code_d  = held_code_q;
    ab_idx_d     = ab_idx_q;
    mac_emit     = 1'b0;
    mac_evt      = '0;
    abort_pend_d = abort_pend_q | (esc_abort && (state_q != ST_ABORT));

    case (state_q)
      ST_IDLE: begin
        if (macro_start) begin
          rom_addr_d = macro_base;
          busy_d     = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = abort_pend_q ? ST_ABORT : ST_DECODE;
      end
      ST_DECODE: begin
        if (abort_pend_q) begin
          state_d = ST_ABORT;
        end else begin
          cur_op_d  = rom_data[9:8];
          cur_arg_d = rom_data[7:0];
          case (rom_data[9:8])
            OP_END: begin
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
            OP_WAIT: begin
              dly_d   = DLY_W'(32'(rom_data[7:0]) * 32'(WAIT_UNIT));
              state_d = ST_DELAY;
            end
            default: state_d = ST_EMIT;
          endcase
        end
      end
      ST_EMIT: begin
        if (abort_pend_q) begin
          state_d = ST_ABORT;
        end else if (gap_zero) begin
          mac_emit        = 1'b1;
          mac_evt.pressed = (cur_op_q == OP_PRESS);
          mac_evt.code    = cur_arg_q;
          if (cur_op_q == OP_PRESS) begin
            if (!held_hit && free_ok) begin
              held_vld_d[free_idx]  = 1'b1;
              held_code_d[free_idx] = cur_arg_q;
            end
          end else begin
            for (int i = 0; i < HELD_N; i++) begin
              if (held_vld_q[i] && (held_code_q[i] == cur_arg_q)) held_vld_d[i] = 1'b0;
            end
          end
          rom_addr_d = rom_addr_q + ADDR_ONE;
          state_d    = ST_FETCH;
        end
      end
      ST_DELAY: begin
        if (abort_pend_q) begin
          state_d = ST_ABORT;
        end else if (dly_q == '0) begin
          rom_addr_d = rom_addr_q + ADDR_ONE;
          state_d    = ST_FETCH;
        end else begin
          dly_d = dly_q - DLY_ONE;
        end
      end
      ST_ABORT: begin
        // Walk the table one slot per step; empty slots cost one cycle
        if (ab_idx_q == AB_DONE) begin
          held_vld_d = '0;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else if (!held_vld_q[ab_idx_q[1:0]]) begin
          ab_idx_d = ab_idx_q + 3'd1;
        end else if (gap_zero) begin
          mac_emit     = 1'b1;
          mac_evt.code = held_code_q[ab_idx_q[1:0]];
          ab_idx_d     = ab_idx_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_ABORT && state_q != ST_ABORT) ab_idx_d = '0;
    if (state_d == ST_ABORT || state_d == ST_IDLE) abort_pend_d = 1'b0;
  end

  // Output arbitration and pacing. The FIFO only drains in IDLE, where the
  // FSM never emits, so the two sources never collide.
  always_comb begin
    fifo_pop  = (state_q == ST_IDLE) && !fifo_empty && gap_zero;
    emit      = mac_emit || fifo_pop;
    emit_evt  = mac_emit ? mac_evt : fifo_dout;
    key_out_d = emit ? {~key_out_q[10], emit_evt} : key_out_q;
    if (emit)           gap_d = GAP_LOAD;
    else if (!gap_zero) gap_d = gap_q - GAP_ONE;
    else                gap_d = gap_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      tog_q        <= 1'b0;
      rom_addr_q   <= '0;
      key_out_q    <= '0;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
      abort_pend_q <= 1'b0;
      gap_q        <= '0;
      dly_q        <= '0;
      cur_op_q     <= OP_END;
      cur_arg_q    <= '0;
      held_vld_q   <= '0;
      held_code_q  <= '0;
      ab_idx_q     <= '0;
    end else begin
      state_q      <= state_d;
      tog_q        <= tog_d;
      rom_addr_q   <= rom_addr_d;
      key_out_q    <= key_out_d;
      busy_q       <= busy_d;
      ovf_q        <= ovf_d;
      abort_pend_q <= abort_pend_d;
      gap_q        <= gap_d;
      dly_q        <= dly_d;
      cur_op_q     <= cur_op_d;
      cur_arg_q    <= cur_arg_d;
      held_vld_q   <= held_vld_d;
      held_code_q  <= held_code_d;
      ab_idx_q     <= ab_idx_d;
    end
  end

endmodule

// File: tb/tb_key_event_sched.sv
// tb_key_event_sched: directed test of key_event_sched with a small gap,
// a short wait unit and a behavioural synchronous macro ROM. Emitted events
// are captured with their cycle number and compared against hand-derived
// expected events in one linear directed sequence.
module tb_key_event_sched;

  localparam int GAP   = 4;
  localparam int WU    = 10;
  localparam int DEPTH = 8;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key = '0;
  logic        macro_start = 1'b0;
  logic [7:0]  macro_base = '0;
  logic [7:0]  rom_addr;
  logic [9:0]  rom_data;
  logic [10:0] key_out;
  logic        busy;
  logic        ovf;

  logic [9:0]  rom [256];

  key_event_sched #(
    .GAP_CYCLES (GAP),
    .WAIT_UNIT  (WU),
    .LIVE_DEPTH (DEPTH),
    .ROM_AW     (8)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ps2_key     (ps2_key),
    .macro_start (macro_start),
    .macro_base  (macro_base),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .key_out     (key_out),
    .busy        (busy),
    .ovf         (ovf)
  );

  always #5 clk_sys = ~clk_sys;

  // Synchronous ROM: data follows the address one clock later
  always @(posedge clk_sys) rom_data <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    logic [10:0] k;
    int          c;
  } obs_t;

  obs_t        evq[$];
  logic [10:0] prev_k = '0;
  logic        prev_busy = 1'b0;
  int          last_emit_c = -1000;
  int          min_gap = 1000000;
  int          ovf_cnt = 0;
  int          busy_fall_c = 0;

  // Capture every change of key_out with the cycle it appeared in
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      prev_k    = '0;
      prev_busy = 1'b0;
    end else begin
      if (key_out !== prev_k) begin
        evq.push_back('{key_out, cyc});
        if (cyc - last_emit_c < min_gap) min_gap = cyc - last_emit_c;
        last_emit_c = cyc;
        prev_k      = key_out;
      end
      if (ovf === 1'b1) ovf_cnt++;
      if (prev_busy && !busy) busy_fall_c = cyc;
      prev_busy = busy;
    end
  end

  int   total = 0;
  int   bad = 0;
  logic exp_tog = 1'b0;
  int   c0, c1, c2, c3, c4, c5, ovf_base;
  logic [7:0] ovf_codes [9];

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_sys);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] ev);
    ps2_key = {~ps2_key[10], ev};
    tick(1);
  endtask

  task automatic startMacro(input logic [7:0] base);
    macro_base  = base;
    macro_start = 1'b1;
    tick(1);
    macro_start = 1'b0;
  endtask

  task automatic waitEvents(input int n, input int budget, input string tag);
    int k = 0;
    while (evq.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    checkOutput({tag, "_timeout"}, 32'(evq.size() >= n), 32'd1);
  endtask

  task automatic expectEvent(input string tag, input logic [9:0] ev, output int c);
    obs_t o;
    exp_tog = ~exp_tog;
    if (evq.size() == 0) begin
      c = 0;
      checkOutput(tag, 32'hDEAD, {21'b0, exp_tog, ev});
    end else begin
      o = evq.pop_front();
      c = o.c;
      checkOutput(tag, 32'(o.k), {21'b0, exp_tog, ev});
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 10'h000;
    // Macro A: J press/release, wait 2 units, Enter press/release, end
    rom[8'h10] = 10'h13B; rom[8'h11] = 10'h23B; rom[8'h12] = 10'h302;
    rom[8'h13] = 10'h15A; rom[8'h14] = 10'h25A; rom[8'h15] = 10'h000;
    // Macro B: press 0x12 and 0x1A, then a long wait to be aborted
    rom[8'h20] = 10'h112; rom[8'h21] = 10'h11A; rom[8'h22] = 10'h3FF;
    rom[8'h23] = 10'h000;
    // Macro C: 5-unit wait holding the live FIFO closed
    rom[8'h30] = 10'h305; rom[8'h31] = 10'h000;
    // Macro D: space press/release twice, interrupted by reset
    rom[8'h40] = 10'h129; rom[8'h41] = 10'h229; rom[8'h42] = 10'h129;
    rom[8'h43] = 10'h229; rom[8'h44] = 10'h000;
    // Macro E: straddles the top of the ROM; rom[0] holds END
    rom[8'hFE] = 10'h144; rom[8'hFF] = 10'h244;
    ovf_codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

    tick(3);
    checkOutput("rst_key_out", 32'(key_out), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_ovf", 32'(ovf), 32'h0);
    checkOutput("rst_rom_addr", 32'(rom_addr), 32'h0);
    reset_n = 1'b1;
    tick(2);

    $display("[TB] live events only");
    applyStimulus(10'h21C);
    applyStimulus(10'h21B);
    applyStimulus(10'h223);
    waitEvents(3, 50, "live");
    expectEvent("live0", 10'h21C, c0);
    expectEvent("live1", 10'h21B, c1);
    expectEvent("live2", 10'h223, c2);
    checkOutput("live_gap01", 32'((c1 - c0) >= GAP), 32'd1);
    checkOutput("live_gap12", 32'((c2 - c1) >= GAP), 32'd1);
    tick(10);

    $display("[TB] macro with wait, live events queued meanwhile");
    startMacro(8'h10);
    checkOutput("macA_busy", 32'(busy), 32'd1);
    tick(3);
    applyStimulus(10'h01C);
    applyStimulus(10'h01B);
    waitEvents(6, 300, "macA");
    expectEvent("macA_jp", 10'h23B, c0);
    expectEvent("macA_jr", 10'h03B, c1);
    expectEvent("macA_ep", 10'h25A, c2);
    expectEvent("macA_er", 10'h05A, c3);
    checkOutput("macA_wait", 32'((c2 - c1) >= 2 * WU), 32'd1);
    checkOutput("macA_busy_fall", 32'(busy_fall_c - c3), 32'd2);
    expectEvent("macA_live0", 10'h01C, c4);
    expectEvent("macA_live1", 10'h01B, c5);
    checkOutput("macA_live_after", 32'(c4 > busy_fall_c), 32'd1);
    tick(10);

    $display("[TB] ESC abort during wait");
    startMacro(8'h20);
    waitEvents(2, 100, "macB");
    expectEvent("macB_p12", 10'h212, c0);
    expectEvent("macB_p1A", 10'h21A, c1);
    tick(10);
    checkOutput("macB_busy", 32'(busy), 32'd1);
    applyStimulus(10'h276);
    waitEvents(2, 100, "abort");
    expectEvent("abort_r12", 10'h012, c0);
    expectEvent("abort_r1A", 10'h01A, c1);
    tick(5);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_no_esc", 32'(evq.size()), 32'd0);
    applyStimulus(10'h076);
    waitEvents(1, 50, "esc_rel");
    expectEvent("esc_rel", 10'h076, c0);
    tick(10);

    $display("[TB] live FIFO overflow while macro holds it");
    ovf_base = ovf_cnt;
    startMacro(8'h30);
    tick(2);
    for (int i = 0; i < 9; i++) applyStimulus({2'b10, ovf_codes[i]});
    tick(3);
    checkOutput("ovf_once", 32'(ovf_cnt - ovf_base), 32'd1);
    checkOutput("ovf_held", 32'(evq.size()), 32'd0);
    waitEvents(8, 200, "ovf_drain");
    for (int i = 0; i < 8; i++) expectEvent($sformatf("ovf_ev%0d", i), {2'b10, ovf_codes[i]}, c0);
    tick(3 * GAP);
    checkOutput("ovf_dropped", 32'(evq.size()), 32'd0);

    $display("[TB] macro wrapping past top of ROM");
    startMacro(8'hFE);
    waitEvents(2, 100, "wrap");
    expectEvent("wrap_p44", 10'h244, c0);
    expectEvent("wrap_r44", 10'h044, c1);
    tick(5);
    checkOutput("wrap_busy", 32'(busy), 32'd0);
    checkOutput("wrap_rom_addr", 32'(rom_addr), 32'h00);
    tick(5);

    $display("[TB] reset while waiting to emit");
    startMacro(8'h40);
    waitEvents(1, 100, "macD");
    expectEvent("macD_p29", 10'h229, c0);
    tick(2);
    reset_n = 1'b0;
    #1;
    checkOutput("rstD_key_out", 32'(key_out), 32'h0);
    checkOutput("rstD_busy", 32'(busy), 32'h0);
    tick(3);
    reset_n = 1'b1;
    tick(30);
    checkOutput("rstD_quiet", 32'(evq.size()), 32'd0);
    checkOutput("rstD_busy_after", 32'(busy), 32'h0);
    checkOutput("rstD_key_after", 32'(key_out), 32'h0);
    checkOutput("min_gap", 32'(min_gap >= GAP), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
